// File: rtl/out_port_fifo.sv
// out_port_fifo: captures CPU OUT bytes into a small FIFO behind a registered head, drained over valid/ready.
module out_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             cpu_stall,
  output logic             ext_valid,
  output logic [WIDTH-1:0] ext_data,
  input  logic             ext_ready,
  output logic [AW:0]      count,
  output logic             overflow
);
  typedef enum logic {EMPTY, VALID} head_t;
  head_t head_state, head_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] stored;
  logic pop, push, load;
  // stored = entries still in the array, i.e. not yet moved into the head register
  assign ext_valid = head_state == VALID;
  assign cpu_stall = count == (AW+1)'(DEPTH);
  assign stored = count - (AW+1)'(ext_valid);
  assign pop = ext_valid && ext_ready;
  assign push = wr_en && (!cpu_stall || pop);
  assign load = (!ext_valid || pop) && (stored != '0 || push);
  always_comb head_next = load ? VALID : (pop ? EMPTY : head_state);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      head_state <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ext_data <= '0;
      overflow <= 1'b0;
    end else begin
      head_state <= head_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // with nothing queued behind the head, a new byte is registered straight into it
      if (load) begin
        ext_data <= stored != '0 ? mem[rd_ptr] : wr_data;
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push && !pop) - (AW+1)'(pop && !push);
      if (wr_en && !push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_out_port_fifo.sv
// tb_out_port_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_out_port_fifo;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0, wr_en = 0, ext_ready = 0;
  logic [7:0] wr_data = 0;
  logic cpu_stall, ext_valid, overflow;
  logic [7:0] ext_data;
  logic [2:0] count;
  int tests = 0, fails = 0;
  logic [7:0] q[$];
  logic m_ovf = 0;

  out_port_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ext_ready), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
    logic mp, mpush;
    wr_en = w; wr_data = d; ext_ready = r; reset = rs;
    @(posedge clk);
    if (rs) begin
      q.delete(); m_ovf = 0;
    end else begin
      mp = q.size() > 0 && r;
      mpush = w && (q.size() < DEPTH || mp);
      if (mp) void'(q.pop_front());
      if (mpush) q.push_back(d);
      if (w && !mpush) m_ovf = 1;
    end
    #1;
    wr_en = 0; ext_ready = 0; reset = 0;
  endtask

  task automatic test_reset;
    step(1, 8'hFF, 1, 1);
    step(1, 8'hFE, 1, 1);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (ext_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ext_valid); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    tests++; if (ext_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", ext_data); end
  endtask

  task automatic test_latency;
    step(1, 8'h11, 0, 0);
    tests++; if (ext_valid !== 1'b1 || ext_data !== 8'h11) begin fails++; $display("FAIL lat_first got v=%b d=%h want v=1 d=11", ext_valid, ext_data); end
    step(1, 8'h22, 0, 0);
    tests++; if (count !== 3'd2 || ext_data !== 8'h11) begin fails++; $display("FAIL lat_count got c=%0d d=%h want c=2 d=11", count, ext_data); end
    step(0, 0, 1, 0);
    tests++; if (ext_valid !== 1'b1 || ext_data !== 8'h22) begin fails++; $display("FAIL lat_second got v=%b d=%h want v=1 d=22", ext_valid, ext_data); end
    step(0, 0, 1, 0);
    tests++; if (ext_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL lat_empty got v=%b c=%0d want v=0 c=0", ext_valid, count); end
  endtask

  task automatic test_overflow;
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hA0 + 8'(i), 0, 0);
      if (i == 3) begin
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL ovf_stall got %b want 1", cpu_stall); end
      end
    end
    tests++; if (overflow !== 1'b1 || count !== 3'd4) begin fails++; $display("FAIL ovf_flag got o=%b c=%0d want o=1 c=4", overflow, count); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (ext_valid !== 1'b1 || ext_data !== 8'hA0 + 8'(i)) begin fails++; $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, ext_valid, ext_data, 8'hA0 + 8'(i)); end
      step(0, 0, 1, 0);
    end
    tests++; if (overflow !== 1'b1 || ext_valid !== 1'b0) begin fails++; $display("FAIL ovf_sticky got o=%b v=%b want o=1 v=0", overflow, ext_valid); end
  endtask

  task automatic test_full_simul;
    logic [7:0] exp [4];
    exp[0] = 8'h51; exp[1] = 8'h52; exp[2] = 8'h53; exp[3] = 8'h5C;
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h50 + 8'(i), 0, 0);
    step(1, 8'h5C, 1, 0);
    tests++; if (count !== 3'd4 || cpu_stall !== 1'b1) begin fails++; $display("FAIL simul_count got c=%0d s=%b want c=4 s=1", count, cpu_stall); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (ext_data !== exp[i]) begin fails++; $display("FAIL simul_drain%0d got %h want %h", i, ext_data, exp[i]); end
      step(0, 0, 1, 0);
    end
    tests++; if (overflow !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL simul_end got o=%b c=%0d want o=0 c=0", overflow, count); end
  endtask

  task automatic test_wrap;
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(i), 1, 0);
      tests++; if (ext_valid !== 1'b1 || ext_data !== 8'(i) || count !== 3'd1) begin fails++; $display("FAIL wrap%0d got v=%b d=%h c=%0d want v=1 d=%h c=1", i, ext_valid, ext_data, count, 8'(i)); end
    end
    step(0, 0, 1, 0);
    tests++; if (ext_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL wrap_end got v=%b c=%0d want v=0 c=0", ext_valid, count); end
  endtask

  task automatic test_reset_midstream;
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0);
    step(0, 0, 1, 1);
    tests++; if (ext_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL mid_reset got v=%b c=%0d want v=0 c=0", ext_valid, count); end
    step(1, 8'h77, 0, 0);
    tests++; if (ext_valid !== 1'b1 || ext_data !== 8'h77 || count !== 3'd1) begin fails++; $display("FAIL mid_first got v=%b d=%h c=%0d want v=1 d=77 c=1", ext_valid, ext_data, count); end
  endtask

  task automatic test_random;
    logic w, r, rs;
    logic [7:0] d;
    step(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      w = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) == 0;
      rs = $urandom_range(0, 99) == 0;
      d = 8'($urandom);
      step(w, d, r, rs);
      tests++;
      if (count !== 3'(q.size()) || ext_valid !== (q.size() > 0) || cpu_stall !== (q.size() == DEPTH) ||
          overflow !== m_ovf || (q.size() > 0 && ext_data !== q[0])) begin
        fails++;
        $display("FAIL rand%0d got c=%0d v=%b d=%h s=%b o=%b want c=%0d v=%b d=%h s=%b o=%b", i, count, ext_valid,
                 ext_data, cpu_stall, overflow, q.size(), q.size() > 0, q.size() > 0 ? q[0] : 8'h00,
                 q.size() == DEPTH, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_overflow;
    test_full_simul;
    test_wrap;
    test_reset_midstream;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
